pipeline_hazard_ctrl: RTL and testbench

// - Central sequencer for the fetch/decode/execute/memory pipeline: pc and IF/ID enables, ID/EX bubble, jump flush, end-of-program drain.
// - Keeps a write scoreboard for the int (2^REGI_BITS) and vector (2^VECT_BITS) register files.
// - Stalls decode on RAW hazards.
// - Zero-extends the 10-bit jump address to the REGI_SIZE-bit pc.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipeline_hazard_ctrl_if.sv | 55 +++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
// Contents:
//   pctl_state_t : sequencer states
//   JUMP_BITS    : width of the jump address produced by execute
//   zext_jump()  : widens a jump address to a pc value (also used by the pc mux)
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } pctl_state_t;

    localparam int JUMP_BITS   = 10;
    // Widest pc any user may ask for; callers cast down to their own pc width.
    localparam int PC_MAX_BITS = 32;

    function automatic logic [PC_MAX_BITS-1:0] zext_jump(input logic [JUMP_BITS-1:0] addr);
        return {{(PC_MAX_BITS-JUMP_BITS){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/sequencing controller.
// master : pipeline side (drives decode/execute/writeback info, receives controls)
// slave  : controller side (pipeline_hazard_ctrl)
interface pipeline_hazard_ctrl_if #(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int JUMP_BITS = 10
);
    logic                 start_i;
    logic                 dec_valid_i;
    logic [REGI_BITS-1:0] dec_src1_i;
    logic                 dec_src1_int_i;
    logic                 dec_src1_vec_i;
    logic [REGI_BITS-1:0] dec_src2_i;
    logic                 dec_src2_int_i;
    logic                 dec_src2_vec_i;
    logic [REGI_BITS-1:0] dec_dst_int_i;
    logic                 dec_wr_int_i;
    logic [VECT_BITS-1:0] dec_dst_vec_i;
    logic                 dec_wr_vec_i;
    logic                 dec_end_i;
    logic                 ex_jump_i;
    logic [JUMP_BITS-1:0] ex_jump_addr_i;
    logic                 wb_wr_int_i;
    logic [REGI_BITS-1:0] wb_dst_int_i;
    logic                 wb_wr_vec_i;
    logic [VECT_BITS-1:0] wb_dst_vec_i;
    logic                 pc_en_o;
    logic                 ifid_en_o;
    logic                 ifid_flush_o;
    logic                 idex_bubble_o;
    logic                 pc_sel_o;
    logic [REGI_SIZE-1:0] pc_target_o;
    logic                 halted_o;
    logic [15:0]          stall_cnt_o;

    modport master (
        output start_i, dec_valid_i, dec_src1_i, dec_src1_int_i, dec_src1_vec_i,
               dec_src2_i, dec_src2_int_i, dec_src2_vec_i, dec_dst_int_i, dec_wr_int_i,
               dec_dst_vec_i, dec_wr_vec_i, dec_end_i, ex_jump_i, ex_jump_addr_i,
               wb_wr_int_i, wb_dst_int_i, wb_wr_vec_i, wb_dst_vec_i,
        input  pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, pc_sel_o,
               pc_target_o, halted_o, stall_cnt_o
    );

    modport slave (
        input  start_i, dec_valid_i, dec_src1_i, dec_src1_int_i, dec_src1_vec_i,
               dec_src2_i, dec_src2_int_i, dec_src2_vec_i, dec_dst_int_i, dec_wr_int_i,
               dec_dst_vec_i, dec_wr_vec_i, dec_end_i, ex_jump_i, ex_jump_addr_i,
               wb_wr_int_i, wb_dst_int_i, wb_wr_vec_i, wb_dst_vec_i,
        output pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, pc_sel_o,
               pc_target_o, halted_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Write scoreboard: one busy bit per register, set on issue, cleared on writeback.
// Ports:
//   clk_i, rst_i        : clock, async active-low reset
//   set_en / set_idx    : mark a register as having a pending writer
//   clr_en / clr_idx    : writeback commit; ignored if the register is not busy
//   q1_idx / q2_idx     : query indices -> q1_busy / q2_busy (writeback bypassed)
//   empty               : no register busy after this cycle's set/clear
module reg_scoreboard #(
    parameter int IDX_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                set_en,
    input  logic [IDX_BITS-1:0] set_idx,
    input  logic                clr_en,
    input  logic [IDX_BITS-1:0] clr_idx,
    input  logic [IDX_BITS-1:0] q1_idx,
    input  logic [IDX_BITS-1:0] q2_idx,
    output logic                q1_busy,
    output logic                q2_busy,
    output logic                empty
);
    localparam int              NREGS = 2 ** IDX_BITS;
    localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic [NREGS-1:0] busy_next_s;

    // Next busy vector; a set wins over a same-cycle clear of the same register.
    always_comb begin
        if (set_en) begin
            set_mask_s = ONE_HOT0 << set_idx;
        end else begin
            set_mask_s = {NREGS{1'b0}};
        end
        if (clr_en) begin
            clr_mask_s = ONE_HOT0 << clr_idx;
        end else begin
            clr_mask_s = {NREGS{1'b0}};
        end
        busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end

    // A register being committed this cycle is readable through the bypass.
    assign q1_busy = busy_r[q1_idx] & ~clr_mask_s[q1_idx];
    assign q2_busy = busy_r[q2_idx] & ~clr_mask_s[q2_idx];
    // Looks at the next state so drain can finish on the cycle of the last commit.
    assign empty   = (busy_next_s == {NREGS{1'b0}});

    // Busy bit storage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the IF/ID/EX/MEM pipeline: pc and IF/ID enables,
// ID/EX bubble on RAW hazards, flush after a taken jump, drain/halt on END.
// Ports:
//   clk_i, rst_i : clock (rising edge), async active-low reset
//   bus (slave)  : decode/execute/writeback info in; pc/pipe controls,
//                  jump target, halted flag and stall counter out
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGI_BITS = 4,
    parameter int VECT_BITS = 2,
    parameter int REGI_SIZE = 16,
    parameter int JUMP_BITS = 10,
    parameter int FLUSH_CYC = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int                  CNT_BITS   = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_BITS-1:0] FLUSH_LOAD = CNT_BITS'(FLUSH_CYC - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

    pctl_state_t         state_r;
    logic [CNT_BITS-1:0] flush_cnt_r;
    logic [15:0]         stall_cnt_r;

    logic int_busy1_s, int_busy2_s, int_empty_s;
    logic vec_busy1_s, vec_busy2_s, vec_empty_s;
    logic hazard_s, issue_s, stall_s;
    logic pc_en_s, ifid_en_s, ifid_flush_s, bubble_s, pc_sel_s;

    reg_scoreboard #(.IDX_BITS(REGI_BITS)) u_int_sb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_en  (issue_s & bus.dec_wr_int_i),
        .set_idx (bus.dec_dst_int_i),
        .clr_en  (bus.wb_wr_int_i),
        .clr_idx (bus.wb_dst_int_i),
        .q1_idx  (bus.dec_src1_i),
        .q2_idx  (bus.dec_src2_i),
        .q1_busy (int_busy1_s),
        .q2_busy (int_busy2_s),
        .empty   (int_empty_s)
    );

    reg_scoreboard #(.IDX_BITS(VECT_BITS)) u_vec_sb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_en  (issue_s & bus.dec_wr_vec_i),
        .set_idx (bus.dec_dst_vec_i),
        .clr_en  (bus.wb_wr_vec_i),
        .clr_idx (bus.wb_dst_vec_i),
        .q1_idx  (bus.dec_src1_i[VECT_BITS-1:0]),
        .q2_idx  (bus.dec_src2_i[VECT_BITS-1:0]),
        .q1_busy (vec_busy1_s),
        .q2_busy (vec_busy2_s),
        .empty   (vec_empty_s)
    );

    assign hazard_s = bus.dec_valid_i &
                      ((bus.dec_src1_int_i & int_busy1_s) | (bus.dec_src1_vec_i & vec_busy1_s) |
                       (bus.dec_src2_int_i & int_busy2_s) | (bus.dec_src2_vec_i & vec_busy2_s));
    // A jump squashes the decode instruction and takes priority over a stall.
    assign issue_s  = (state_r == RUN) & bus.dec_valid_i & ~hazard_s & ~bus.ex_jump_i;
    assign stall_s  = (state_r == RUN) & hazard_s & ~bus.ex_jump_i;

    // Sequencer state, flush countdown and saturating stall counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            flush_cnt_r <= {CNT_BITS{1'b0}};
            stall_cnt_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= bus.start_i ? RUN : IDLE;
                end
                RUN: begin
                    if (bus.ex_jump_i) begin
                        flush_cnt_r <= FLUSH_LOAD;
                        state_r     <= (FLUSH_CYC > 1) ? FLUSH : RUN;
                    end else if (issue_s && bus.dec_end_i) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FLUSH: begin
                    // A new jump restarts the countdown with its own target.
                    if (bus.ex_jump_i) begin
                        flush_cnt_r <= FLUSH_LOAD;
                        state_r     <= FLUSH;
                    end else if (flush_cnt_r <= CNT_ONE) begin
                        flush_cnt_r <= {CNT_BITS{1'b0}};
                        state_r     <= RUN;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - CNT_ONE;
                        state_r     <= FLUSH;
                    end
                end
                DRAIN: begin
                    state_r <= (int_empty_s && vec_empty_s) ? HALT : DRAIN;
                end
                HALT: begin
                    state_r <= HALT;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Pipe controls; jump and hazard react within the same cycle.
    always_comb begin
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        ifid_flush_s = 1'b0;
        bubble_s     = 1'b1;
        pc_sel_s     = 1'b0;
        case (state_r)
            IDLE: begin
                ifid_flush_s = 1'b1;
            end
            RUN: begin
                if (bus.ex_jump_i) begin
                    pc_sel_s     = 1'b1;
                    pc_en_s      = 1'b1;
                    ifid_flush_s = 1'b1;
                end else if (hazard_s) begin
                    pc_en_s = 1'b0;
                end else begin
                    pc_en_s   = 1'b1;
                    ifid_en_s = 1'b1;
                    bubble_s  = ~issue_s;
                end
            end
            FLUSH: begin
                pc_en_s      = 1'b1;
                ifid_flush_s = 1'b1;
                pc_sel_s     = bus.ex_jump_i;
            end
            DRAIN: begin
                pc_en_s = 1'b0;
            end
            HALT: begin
                pc_en_s = 1'b0;
            end
            default: begin
                pc_en_s = 1'b0;
            end
        endcase
    end

    assign bus.pc_en_o       = pc_en_s;
    assign bus.ifid_en_o     = ifid_en_s;
    assign bus.ifid_flush_o  = ifid_flush_s;
    assign bus.idex_bubble_o = bubble_s;
    assign bus.pc_sel_o      = pc_sel_s;
    assign bus.pc_target_o   = REGI_SIZE'(zext_jump(bus.ex_jump_addr_i));
    assign bus.halted_o      = (state_r == HALT);
    assign bus.stall_cnt_o   = stall_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes expected output
// values into a queue; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REGI_BITS(4), .VECT_BITS(2), .REGI_SIZE(16), .JUMP_BITS(10)) bus ();

    pipeline_hazard_ctrl #(
        .REGI_BITS(4), .VECT_BITS(2), .REGI_SIZE(16), .JUMP_BITS(10), .FLUSH_CYC(2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    localparam int S_PCEN = 0, S_IFEN = 1, S_FLUSH = 2, S_BUB = 3;
    localparam int S_PCSEL = 4, S_HALT = 5, S_STALL = 6, S_TGT = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PCEN:  return 32'(bus.pc_en_o);
            S_IFEN:  return 32'(bus.ifid_en_o);
            S_FLUSH: return 32'(bus.ifid_flush_o);
            S_BUB:   return 32'(bus.idex_bubble_o);
            S_PCSEL: return 32'(bus.pc_sel_o);
            S_HALT:  return 32'(bus.halted_o);
            S_STALL: return 32'(bus.stall_cnt_o);
            S_TGT:   return 32'(bus.pc_target_o);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is compared at that cycle's negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (actual(e.sel) !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", e.name, actual(e.sel), e.val, $time);
            end
        end
    end

    task automatic chk(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.start_i = 1'b0;        bus.dec_valid_i = 1'b0;
        bus.dec_src1_i = 4'd0;     bus.dec_src1_int_i = 1'b0; bus.dec_src1_vec_i = 1'b0;
        bus.dec_src2_i = 4'd0;     bus.dec_src2_int_i = 1'b0; bus.dec_src2_vec_i = 1'b0;
        bus.dec_dst_int_i = 4'd0;  bus.dec_wr_int_i = 1'b0;
        bus.dec_dst_vec_i = 2'd0;  bus.dec_wr_vec_i = 1'b0;   bus.dec_end_i = 1'b0;
        bus.ex_jump_i = 1'b0;      bus.ex_jump_addr_i = 10'd0;
        bus.wb_wr_int_i = 1'b0;    bus.wb_dst_int_i = 4'd0;
        bus.wb_wr_vec_i = 1'b0;    bus.wb_dst_vec_i = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        rst = 1'b0;
        tick();
        // reset values
        chk("rst_pc_en", S_PCEN, 32'd0);   chk("rst_flush", S_FLUSH, 32'd1);
        chk("rst_bubble", S_BUB, 32'd1);   chk("rst_halted", S_HALT, 32'd0);
        chk("rst_stall", S_STALL, 32'd0);  chk("rst_pc_sel", S_PCSEL, 32'd0);
        chk("rst_target", S_TGT, 32'd0);
        tick();
        rst = 1'b1;
        // IDLE
        bus.start_i = 1'b1;
        chk("idle_pc_en", S_PCEN, 32'd0);  chk("idle_bubble", S_BUB, 32'd1);
        tick();
        // RAW int on r3 with writeback bypass on third cycle
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd3;
        chk("raw_issue_pc_en", S_PCEN, 32'd1); chk("raw_issue_ifen", S_IFEN, 32'd1);
        chk("raw_issue_bub", S_BUB, 32'd0);
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd3; bus.dec_src1_int_i = 1'b1;
        chk("raw_st1_pc_en", S_PCEN, 32'd0); chk("raw_st1_bub", S_BUB, 32'd1);
        chk("raw_st1_cnt", S_STALL, 32'd0);
        tick();
        chk("raw_st2_pc_en", S_PCEN, 32'd0); chk("raw_st2_cnt", S_STALL, 32'd1);
        tick();
        bus.wb_wr_int_i = 1'b1; bus.wb_dst_int_i = 4'd3;
        chk("raw_bypass_pc_en", S_PCEN, 32'd1); chk("raw_bypass_bub", S_BUB, 32'd0);
        chk("raw_stall_cnt2", S_STALL, 32'd2);
        tick();
        // vector busy 1, int read 1
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_vec_i = 1'b1; bus.dec_dst_vec_i = 2'd1;
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd1; bus.dec_src1_int_i = 1'b1;
        chk("iso_int_pc_en", S_PCEN, 32'd1); chk("iso_int_bub", S_BUB, 32'd0);
        tick();
        // int busy 1 (vec 1 cleared same cycle), then vector read 1
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd1;
        bus.wb_wr_vec_i = 1'b1; bus.wb_dst_vec_i = 2'd1;
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src2_i = 4'd1; bus.dec_src2_vec_i = 1'b1;
        chk("iso_vec_pc_en", S_PCEN, 32'd1); chk("iso_vec_bub", S_BUB, 32'd0);
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src2_i = 4'd1; bus.dec_src2_int_i = 1'b1;
        chk("src2_int_stall", S_PCEN, 32'd0); chk("src2_cnt", S_STALL, 32'd2);
        tick();
        clr(); bus.wb_wr_int_i = 1'b1; bus.wb_dst_int_i = 4'd1;
        tick();
        // jump during a hazard stall
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd7;
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd7; bus.dec_src1_int_i = 1'b1;
        bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd9;
        chk("jmp_pre_stall", S_PCEN, 32'd0); chk("jmp_pre_cnt", S_STALL, 32'd3);
        tick();
        bus.ex_jump_i = 1'b1; bus.ex_jump_addr_i = 10'h3FF;
        chk("jmp_pc_sel", S_PCSEL, 32'd1);  chk("jmp_target", S_TGT, 32'h03FF);
        chk("jmp_flush", S_FLUSH, 32'd1);   chk("jmp_pc_en", S_PCEN, 32'd1);
        chk("jmp_bub", S_BUB, 32'd1);       chk("jmp_cnt", S_STALL, 32'd4);
        tick();
        clr();
        chk("flush2_flush", S_FLUSH, 32'd1); chk("flush2_pc_sel", S_PCSEL, 32'd0);
        chk("flush2_pc_en", S_PCEN, 32'd1);  chk("flush2_bub", S_BUB, 32'd1);
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd9; bus.dec_src1_int_i = 1'b1;
        bus.wb_wr_int_i = 1'b1; bus.wb_dst_int_i = 4'd7;
        chk("post_flush_off", S_FLUSH, 32'd0); chk("squash_no_busy", S_PCEN, 32'd1);
        chk("squash_bub", S_BUB, 32'd0);      chk("post_jmp_cnt", S_STALL, 32'd4);
        tick();
        // set/clear collision on r5
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd5;
        tick();
        bus.wb_wr_int_i = 1'b1; bus.wb_dst_int_i = 4'd5;
        chk("coll_issue", S_PCEN, 32'd1);
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd5; bus.dec_src1_int_i = 1'b1;
        chk("coll_stall", S_PCEN, 32'd0); chk("coll_cnt", S_STALL, 32'd4);
        tick();
        bus.wb_wr_int_i = 1'b1; bus.wb_dst_int_i = 4'd5;
        chk("coll_release", S_BUB, 32'd0); chk("coll_cnt2", S_STALL, 32'd5);
        tick();
        // END with vec 2 busy
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_vec_i = 1'b1; bus.dec_dst_vec_i = 2'd2;
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_end_i = 1'b1;
        chk("end_issue", S_PCEN, 32'd1);
        tick();
        clr();
        chk("drain1_pc_en", S_PCEN, 32'd0); chk("drain1_bub", S_BUB, 32'd1);
        chk("drain1_halt", S_HALT, 32'd0);
        tick();
        chk("drain2_pc_en", S_PCEN, 32'd0); chk("drain2_halt", S_HALT, 32'd0);
        tick();
        bus.wb_wr_vec_i = 1'b1; bus.wb_dst_vec_i = 2'd2;
        chk("drain3_pc_en", S_PCEN, 32'd0); chk("drain3_halt", S_HALT, 32'd0);
        tick();
        clr(); bus.start_i = 1'b1;
        chk("halt_flag", S_HALT, 32'd1); chk("halt_pc_en", S_PCEN, 32'd0);
        chk("halt_bub", S_BUB, 32'd1);   chk("halt_cnt", S_STALL, 32'd5);
        tick();
        clr();
        chk("halt_ignores_start", S_HALT, 32'd1); chk("halt_pc_en2", S_PCEN, 32'd0);
        tick();
        // leave HALT through reset, then reset again mid-DRAIN with r4 busy
        rst = 1'b0;
        tick();
        rst = 1'b1; bus.start_i = 1'b1;
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_wr_int_i = 1'b1; bus.dec_dst_int_i = 4'd4;
        bus.dec_end_i = 1'b1;
        chk("d_issue", S_PCEN, 32'd1);
        tick();
        clr();
        chk("d_drain_pc_en", S_PCEN, 32'd0); chk("d_drain_halt", S_HALT, 32'd0);
        tick();
        rst = 1'b0;
        chk("mid_rst_bub", S_BUB, 32'd1);   chk("mid_rst_flush", S_FLUSH, 32'd1);
        chk("mid_rst_halt", S_HALT, 32'd0); chk("mid_rst_cnt", S_STALL, 32'd0);
        chk("mid_rst_pc_en", S_PCEN, 32'd0);
        tick();
        rst = 1'b1; bus.start_i = 1'b1;
        chk("after_rst_halt", S_HALT, 32'd0); chk("after_rst_bub", S_BUB, 32'd1);
        chk("after_rst_cnt", S_STALL, 32'd0); chk("after_rst_pc_en", S_PCEN, 32'd0);
        tick();
        clr(); bus.dec_valid_i = 1'b1; bus.dec_src1_i = 4'd4; bus.dec_src1_int_i = 1'b1;
        chk("sb_cleared_pc_en", S_PCEN, 32'd1); chk("sb_cleared_bub", S_BUB, 32'd0);
        tick();
        // END with empty scoreboards: exactly one DRAIN cycle
        clr(); bus.dec_valid_i = 1'b1; bus.dec_end_i = 1'b1;
        chk("end2_issue", S_PCEN, 32'd1);
        tick();
        clr();
        chk("end2_drain_halt", S_HALT, 32'd0); chk("end2_drain_pc_en", S_PCEN, 32'd0);
        tick();
        chk("end2_halted", S_HALT, 32'd1);
        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
